// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and fixed-latency access sequencer sharing one data memory
// between the CPU load/store path and a DMA/loader port.
module dmem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // CPU port
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_done,
    output logic          o_cpu_stall,
    // DMA port
    input  logic          i_dma_req,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_wdata,
    output logic [DW-1:0] o_dma_rdata,
    output logic          o_dma_done,
    // memory side
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_read,
    output logic          o_mem_write,
    input  logic [DW-1:0] i_mem_rdata,
    // status
    output logic          o_busy,
    output logic          o_owner
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last;   // last served port: 0 = CPU, 1 = DMA
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_cpu_done;
    logic          r_dma_done;
    logic          r_busy;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;

    logic w_any_req;
    logic w_gnt_dma;

    assign w_any_req = i_cpu_req | i_dma_req;
    // On a tie the DMA port wins only if the CPU was served last.
    assign w_gnt_dma = i_dma_req & (~i_cpu_req | ~r_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_dma_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_gnt_dma;
                        r_we        <= w_gnt_dma ? i_dma_we    : i_cpu_we;
                        r_addr      <= w_gnt_dma ? i_dma_addr  : i_cpu_addr;
                        r_wdata     <= w_gnt_dma ? i_dma_wdata : i_cpu_wdata;
                        r_mem_read  <= w_gnt_dma ? ~i_dma_we   : ~i_cpu_we;
                        r_mem_write <= w_gnt_dma ? i_dma_we    : i_cpu_we;
                        r_cnt       <= CW'(MEM_LAT - 1);
                        r_busy      <= 1'b1;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            if (r_owner) r_dma_rdata <= i_mem_rdata;
                            else         r_cpu_rdata <= i_mem_rdata;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_cpu_done  <= ~r_owner;
                        r_dma_done  <= r_owner;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_cpu_done <= 1'b0;
                    r_dma_done <= 1'b0;
                    r_busy     <= 1'b0;
                    r_last     <= r_owner;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_cpu_done  = r_cpu_done;
    assign o_dma_done  = r_dma_done;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_dma_rdata = r_dma_rdata;
    assign o_busy      = r_busy;
    assign o_owner     = r_owner;
    assign o_cpu_stall = i_cpu_req & ~r_cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, cpu_stall, dma_done, mem_read, mem_write, busy, owner;
    logic [31:0] rd_base;

    // MEM_LAT=1 instance signals
    logic        l_cpu_req;
    logic [31:0] l_cpu_addr, l_zero32, l_mem_rdata;
    logic [31:0] l_cpu_rdata, l_dma_rdata, l_mem_addr, l_mem_wdata;
    logic        l_zero, l_cpu_done, l_cpu_stall, l_dma_done, l_mem_read, l_mem_write, l_busy, l_owner;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic prev_busy = 1'b0;

    logic [31:0] exp_cpu[$];
    logic [31:0] exp_dma[$];
    logic [31:0] mdl_cpu_rd, mdl_dma_rd;
    logic        g_owner[$];
    int          g_cyc[$];

    always #5 clk = ~clk;

    // memory model: read data is a function of the address
    assign mem_rdata = rd_base ^ mem_addr;

    dmem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_done(cpu_done), .o_cpu_stall(cpu_stall),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_rdata(dma_rdata), .o_dma_done(dma_done),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_owner(owner)
    );

    dmem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(l_cpu_req), .i_cpu_we(l_zero), .i_cpu_addr(l_cpu_addr), .i_cpu_wdata(l_zero32),
        .o_cpu_rdata(l_cpu_rdata), .o_cpu_done(l_cpu_done), .o_cpu_stall(l_cpu_stall),
        .i_dma_req(l_zero), .i_dma_we(l_zero), .i_dma_addr(l_zero32), .i_dma_wdata(l_zero32),
        .o_dma_rdata(l_dma_rdata), .o_dma_done(l_dma_done),
        .o_mem_addr(l_mem_addr), .o_mem_wdata(l_mem_wdata), .o_mem_read(l_mem_read),
        .o_mem_write(l_mem_write), .i_mem_rdata(l_mem_rdata),
        .o_busy(l_busy), .o_owner(l_owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard monitor: grant log and done/rdata comparison
    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_busy <= busy;
        if (busy && !prev_busy) begin
            g_owner.push_back(owner);
            g_cyc.push_back(cyc);
        end
        if (cpu_done) begin
            if (exp_cpu.size() == 0) chk("cpu_done_unexpected", 32'd1, 32'd0);
            else                     chk("cpu_rdata_sb", cpu_rdata, exp_cpu.pop_front());
        end
        if (dma_done) begin
            if (exp_dma.size() == 0) chk("dma_done_unexpected", 32'd1, 32'd0);
            else                     chk("dma_rdata_sb", dma_rdata, exp_dma.pop_front());
        end
    end

    task automatic push_exp(input bit port, input bit we, input logic [31:0] addr);
        if (!we) begin
            if (port) mdl_dma_rd = rd_base ^ addr;
            else      mdl_cpu_rd = rd_base ^ addr;
        end
        if (port) exp_dma.push_back(mdl_dma_rd);
        else      exp_cpu.push_back(mdl_cpu_rd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl_cpu_rd = '0;
        mdl_dma_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input bit port, input string tag);
        int k;
        for (k = 0; k < 12 && !(port ? dma_done : cpu_done); k++) @(negedge clk);
        if (k >= 12) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit drop_mid);
        push_exp(port, we, addr);
        @(posedge clk); #1;
        if (port) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
        else      begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("busy_c0", busy, 0);
                if (!port) chk("stall_c0", cpu_stall, 1);
            end else if (c <= LAT) begin
                chk("busy", busy, 1);
                chk("mem_read", mem_read, !we);
                chk("mem_write", mem_write, we);
                chk("mem_addr", mem_addr, addr);
                if (we) chk("mem_wdata", mem_wdata, wdata);
                chk("done_early", port ? dma_done : cpu_done, 0);
                if (!port) chk("stall_busy", cpu_stall, (drop_mid && c > 1) ? 1'b0 : 1'b1);
                if (drop_mid && c == 1) begin cpu_req = 0; cpu_addr = 32'h99; end
            end else begin
                chk("done", port ? dma_done : cpu_done, 1);
                chk("other_done", port ? cpu_done : dma_done, 0);
                chk("strobes_resp", {30'd0, mem_read, mem_write}, 0);
                if (!port) chk("stall_done", cpu_stall, 0);
            end
        end
        @(posedge clk); #1;
        if (port) dma_req = 0; else cpu_req = 0;
    endtask

    initial begin
        int k;
        rst_n = 0; rd_base = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        l_cpu_req = 0; l_cpu_addr = 0; l_zero = 0; l_zero32 = 0; l_mem_rdata = 32'h0BADF00D;
        mdl_cpu_rd = 0; mdl_dma_rd = 0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 0);
        chk("rst_dones", {30'd0, cpu_done, dma_done}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_owner", owner, 0);
        rst_n = 1;

        // CPU read
        rd_base = 32'hDEADBEEF ^ 32'h10;
        do_access(0, 0, 32'h10, 32'h0, 0);
        chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // DMA write leaves both rdata registers alone
        rd_base = 32'h5555_0000;
        do_access(1, 1, 32'h40, 32'h12345678, 0);
        chk("wr_cpu_rdata", cpu_rdata, mdl_cpu_rd);
        chk("wr_dma_rdata", dma_rdata, mdl_dma_rd);

        // tie after reset
        do_reset();
        rd_base = 32'h0F0F_0000;
        g_owner.delete(); g_cyc.delete();
        push_exp(0, 0, 32'h100); push_exp(0, 0, 32'h100);
        push_exp(1, 0, 32'h200); push_exp(1, 0, 32'h200);
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        for (k = 0; k < 40 && g_owner.size() < 4; k++) @(negedge clk);
        wait_done(1, "tie_timeout");
        @(posedge clk); #1;
        cpu_req = 0; dma_req = 0;
        chk("tie_grants", g_owner.size(), 4);
        if (g_owner.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("tie_owner", g_owner[i], i % 2);
            for (int i = 1; i < 4; i++) chk("tie_spacing", g_cyc[i] - g_cyc[i-1], LAT + 2);
        end
        chk("tie_cpu_rdata", cpu_rdata, 32'h0F0F_0100);
        chk("tie_dma_rdata", dma_rdata, 32'h0F0F_0200);

        // request dropped mid-access
        rd_base = 32'h7000_0000;
        do_access(0, 0, 32'h20, 32'h0, 1);
        chk("drop_rdata", cpu_rdata, 32'h7000_0020);

        // reset mid-write
        @(posedge clk); #1;
        dma_req = 1; dma_we = 1; dma_addr = 32'h300; dma_wdata = 32'hAAAA5555;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_pre_write", mem_write, 1);
        rst_n = 0; #1;
        chk("rstmid_write", mem_write, 0);
        chk("rstmid_busy", busy, 0);
        dma_req = 0; dma_we = 0;
        mdl_cpu_rd = 0; mdl_dma_rd = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_done", {30'd0, cpu_done, dma_done}, 0);
        end
        rst_n = 1;
        rd_base = 32'h1234_0000;
        g_owner.delete(); g_cyc.delete();
        push_exp(0, 0, 32'h500); push_exp(1, 0, 32'h600);
        @(posedge clk); #1;
        cpu_req = 1; cpu_addr = 32'h500;
        dma_req = 1; dma_addr = 32'h600;
        for (k = 0; k < 10 && g_owner.size() < 1; k++) @(negedge clk);
        chk("rstmid_first_grant_seen", g_owner.size(), 1);
        if (g_owner.size() >= 1) chk("rstmid_first_owner", g_owner[0], 0);
        wait_done(0, "rstmid_cpu_timeout");
        @(posedge clk); #1; cpu_req = 0;
        wait_done(1, "rstmid_dma_timeout");
        @(posedge clk); #1; dma_req = 0;

        // MEM_LAT = 1 instance
        @(posedge clk); #1;
        l_cpu_req = 1; l_cpu_addr = 32'h44;
        @(negedge clk);
        chk("l1_c0_busy", l_busy, 0);
        @(negedge clk);
        chk("l1_busy", l_busy, 1);
        chk("l1_read", l_mem_read, 1);
        chk("l1_addr", l_mem_addr, 32'h44);
        chk("l1_done_early", l_cpu_done, 0);
        @(negedge clk);
        chk("l1_done", l_cpu_done, 1);
        chk("l1_rdata", l_cpu_rdata, 32'h0BADF00D);
        chk("l1_read_off", l_mem_read, 0);
        @(posedge clk); #1; l_cpu_req = 0;
        @(negedge clk);
        chk("l1_idle", {30'd0, l_busy, l_cpu_done}, 0);

        repeat (3) @(negedge clk);
        chk("sb_cpu_empty", exp_cpu.size(), 0);
        chk("sb_dma_empty", exp_dma.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
